// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
//   DEF_WIDTH / DEF_GROUP : default operand width and bits per CLA slice
//   nstg()                : number of pipeline stages (= latency)
//   OP_ADD / OP_SUB       : encoding of the sub input
package cla_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_GROUP = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One CLA slice per stage; a zero group is rejected at elaboration by the top.
  function automatic int unsigned nstg(input int unsigned width, input int unsigned group);
    return (group == 32'd0) ? 32'd0 : width / group;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
//   in_valid/in_ready   : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   master drives operands and out_ready; slave is the adder.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = cla_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice.
//   a, b  : slice operands
//   ci    : carry into the slice
//   s     : slice sum
//   co    : carry out of the slice
//   c_msb : carry into the slice's top bit
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             cc;
  logic             pp;

  assign g = a & b;
  assign p = a ^ b;

  // Flat single-level lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci.
  always_comb begin
    c    = '0;
    cc   = 1'b0;
    pp   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < int'(GROUP); i++) begin
      cc = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      cc     = cc | (pp & ci);
      c[i+1] = cc;
    end
  end

  assign s     = p ^ c[GROUP-1:0];
  assign co    = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of cla_pipe_adder_if
//                a, b, cin, sub in -> sum, cout, ovf out after NSTG stages
//                in_ready is combinational: !out_valid || out_ready
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_pipe_adder_if.slave bus
);

  localparam int unsigned NSTG = nstg(WIDTH, GROUP);

  if (GROUP < 1) begin : g_bad_group
    $fatal(1, "cla_pipe_adder: GROUP must be at least 1");
  end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  logic             adv;
  logic             c0;
  logic [WIDTH-1:0] beff;

  logic [NSTG-1:0]  v_q;
  logic [NSTG-1:0]  v_d;
  logic [NSTG-1:0]  c_q;
  logic [NSTG-1:0]  c_d;
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] a_d [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] b_d [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic [WIDTH-1:0] s_d [NSTG];
  logic             cm  [NSTG];
  logic             ovf_q;
  logic             ovf_d;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign adv          = ~v_q[NSTG-1] | bus.out_ready;
  assign bus.in_ready = adv;

  // Subtract as a + ~b + 1; cin is ignored in that mode.
  assign beff = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
  assign c0   = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;

  for (genvar k = 0; k < int'(NSTG); k++) begin : g_stg
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_nx;
    logic             c_in;
    logic             v_in;
    logic [GROUP-1:0] s_k;
    logic             co_k;

    if (k == 0) begin : g_first
      assign a_in = bus.a;
      assign b_in = beff;
      assign s_in = '0;
      assign c_in = c0;
      assign v_in = bus.in_valid & adv;
    end else begin : g_next
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = s_q[k-1];
      assign c_in = c_q[k-1];
      assign v_in = v_q[k-1];
    end

    cla_group #(
      .GROUP (GROUP)
    ) u_grp (
      .a     (a_in[k*GROUP +: GROUP]),
      .b     (b_in[k*GROUP +: GROUP]),
      .ci    (c_in),
      .s     (s_k),
      .co    (co_k),
      .c_msb (cm[k])
    );

    // Merge this stage's slice into the partial sum travelling down the pipe.
    always_comb begin
      s_nx                    = s_in;
      s_nx[k*GROUP +: GROUP]  = s_k;
    end

    assign v_d[k] = v_in;
    assign c_d[k] = co_k;
    assign a_d[k] = a_in;
    assign b_d[k] = b_in;
    assign s_d[k] = s_nx;
  end

  // Signed overflow: carry into MSB differs from carry out of MSB.
  assign ovf_d = c_d[NSTG-1] ^ cm[NSTG-1];

  // Stage registers, cleared asynchronously so no partial result survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(NSTG); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < int'(NSTG); k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign bus.out_valid = v_q[NSTG-1];
  assign bus.sum       = s_q[NSTG-1];
  assign bus.cout      = c_q[NSTG-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 4-bit clocked CLA adder.
- Splits the WIDTH-bit operation into GROUP-bit CLA slices, one slice per pipeline stage, with the carry registered between stages.
- Adds subtract mode, carry-in, signed overflow and a valid/ready handshake with backpressure.
- Sits in the datapath wherever a wide add must close timing at the `clk` rate.

Parameters:
- WIDTH, 16: operand and sum width; must be a multiple of GROUP.
- GROUP, 4: bits per CLA slice, equal to bits resolved per stage.
- NSTG, WIDTH/GROUP (derived, not overridable): number of pipeline stages, which is also the latency.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts input this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; for sub, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB xor carry out of MSB.

Behaviour:
- Elaboration: WIDTH % GROUP != 0 or GROUP < 1 causes $error/$fatal.
- Reset (rst_n low, asynchronous): all stage valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0.
  - All pipeline data registers clear.
  - in_ready is combinational and equals 1 during reset release.
- Reset asserted mid-operation discards every in-flight operation. No partial result ever appears.
- Operand prep at entry:
  - beff = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage k (k = 0..NSTG-1) computes bits [k*GROUP +: GROUP] from a, beff and the registered carry from stage k-1 (c0 for k=0), using single-level generate/propagate lookahead.
- Each stage registers:
  - its sum slice;
  - the still-unused upper operand slices (skew buffer);
  - its carry out;
  - for the last stage only, the carry into the MSB, which feeds ovf.
- Advance rule: adv = !out_valid || out_ready.
  - in_ready = adv.
  - Every stage register and stage valid bit loads only when adv=1. Otherwise the whole pipe holds (global stall, no bubbles collapse).
  - Stage 0 valid loads in_valid & in_ready.
- Latency: an input accepted at edge T produces out_valid=1 with the correct sum/cout/ovf after edge T+NSTG-1. That is NSTG register stages with no extra output register, given no stall.
- Throughput: one operation per cycle while out_ready=1.
- Output hold: sum/cout/ovf/out_valid are stable while out_valid=1 and out_ready=0.
- Transfer occurs when out_valid & out_ready. Each accepted input yields exactly one output, in order.
- Simultaneous events: out_ready=1 with a full pipe permits a same-cycle input accept. No loss or duplication.
- Wrap-around: the sum is truncated to WIDTH bits; the carry is reported only on cout.
- cin is don't-care when sub=1.

Decomposition:
- Shared package cla_pkg holds:
  - default WIDTH and GROUP;
  - a function computing NSTG;
  - an op-mode constant pair (OP_ADD = 0, OP_SUB = 1).
- One natural sub-module: cla_group.
  - Combinational, GROUP-bit.
  - Inputs: a, b, ci. Outputs: s, co, c_msb (the carry into the slice's top bit).
  - Instantiated NSTG times via generate.

Test Plan:
- WIDTH=4, GROUP=4, a=4'b1111, b=4'b1001, cin=0, sub=0 -> sum=4'b1000, cout=1, ovf=0, out_valid one cycle after accept.
- WIDTH=16, GROUP=4, a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0; out_valid rises 4 cycles after accept, and exactly one result.
- a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, cout=0, ovf=1. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Carry ripple across all stages: a=16'h0FFF, b=16'h0000, cin=1 -> sum=16'h1000, cout=0.
- Stream 8 random ops back-to-back with out_ready toggled (low 3 cycles, high 2, ...):
  - in_ready mirrors adv;
  - outputs hold while stalled;
  - results match the reference model in order, with no loss or duplication.
- Fill the pipe with 3 ops, assert rst_n=0 asynchronously between edges -> out_valid=0, sum=0, cout=0, ovf=0 immediately. After release, none of the 3 ops emerge; a new op a=16'h0002, b=16'h0003 -> sum=16'h0005 after 4 cycles.
